// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the pipeline and the hazard/stall controller.
// master: pipeline side (drives hazard sources, receives stall decisions).
// slave:  controller side.
// Optional macro HAZARD_STALL_PERF_EN adds the stall performance counters.
interface hazard_stall_ctrl_if;
   logic        Req;
   logic [4:0]  d_rs_addr;
   logic [4:0]  d_rt_addr;
   logic [1:0]  d_rs_tuse;
   logic [1:0]  d_rt_tuse;
   logic [4:0]  e_wa;
   logic [1:0]  e_tnew;
   logic [4:0]  m_wa;
   logic [1:0]  m_tnew;
   logic        d_isMD;
   logic        e_md_start;
   logic        e_md_is_div;
   logic        d_isEret;
   logic        e_mtc0_epc;
   logic        m_mtc0_epc;
   logic        Stall;
   logic        IDEX_Flush;
   logic        md_busy;
`ifdef HAZARD_STALL_PERF_EN
   logic [31:0] stall_cycles;
   logic [31:0] md_stall_cycles;

   modport master (
      output Req, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew,
             d_isMD, e_md_start, e_md_is_div, d_isEret, e_mtc0_epc, m_mtc0_epc,
      input  Stall, IDEX_Flush, md_busy, stall_cycles, md_stall_cycles
   );

   modport slave (
      input  Req, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew,
             d_isMD, e_md_start, e_md_is_div, d_isEret, e_mtc0_epc, m_mtc0_epc,
      output Stall, IDEX_Flush, md_busy, stall_cycles, md_stall_cycles
   );
`else
   modport master (
      output Req, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew,
             d_isMD, e_md_start, e_md_is_div, d_isEret, e_mtc0_epc, m_mtc0_epc,
      input  Stall, IDEX_Flush, md_busy
   );

   modport slave (
      input  Req, d_rs_addr, d_rt_addr, d_rs_tuse, d_rt_tuse, e_wa, e_tnew, m_wa, m_tnew,
             d_isMD, e_md_start, e_md_is_div, d_isEret, e_mtc0_epc, m_mtc0_epc,
      output Stall, IDEX_Flush, md_busy
   );
`endif
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Central stall/flush controller for the 5-stage pipeline.
// Stall sources: Tuse/Tnew data hazards, the multicycle mult/div unit, and eret vs.
// an in-flight mtc0 to EPC. Exception requests (Req) suppress all stalling.
// Optional macro HAZARD_STALL_PERF_EN adds stall_cycles / md_stall_cycles counters.
module hazard_stall_ctrl #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10,
   parameter int unsigned CNT_W       = 4
) (
   input logic               clk,
   input logic               reset,
   hazard_stall_ctrl_if.slave bus
);

   localparam logic [CNT_W-1:0] MultLoad = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DivLoad  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CntOne   = CNT_W'(1);

   typedef enum logic [0:0] {StIdle, StBusy} state_e;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             haz_rs, haz_rt, stall_md, stall_er, stall_any, md_load;

   // Same-cycle stall decision from all hazard sources.
   always_comb begin
      haz_rs   = (bus.d_rs_addr != 5'd0) &&
                 ((bus.d_rs_addr == bus.e_wa && bus.d_rs_tuse < bus.e_tnew) ||
                  (bus.d_rs_addr == bus.m_wa && bus.d_rs_tuse < bus.m_tnew));
      haz_rt   = (bus.d_rt_addr != 5'd0) &&
                 ((bus.d_rt_addr == bus.e_wa && bus.d_rt_tuse < bus.e_tnew) ||
                  (bus.d_rt_addr == bus.m_wa && bus.d_rt_tuse < bus.m_tnew));
      stall_md = bus.d_isMD && (bus.md_busy || bus.e_md_start);
      stall_er = bus.d_isEret && (bus.e_mtc0_epc || bus.m_mtc0_epc);
      stall_any = haz_rs | haz_rt | stall_md | stall_er;
      // Req wins: the pipeline registers flush themselves, so no bubble is needed here.
      bus.Stall      = stall_any && !bus.Req && !reset;
      bus.IDEX_Flush = stall_any && !bus.Req && !reset;
   end

   // Busy-counter next state: load on an accepted start, otherwise count down to idle.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      md_load = bus.e_md_start && !bus.Req;
      case (state_q)
         StIdle: begin
            if (md_load) begin
               count_d = bus.e_md_is_div ? DivLoad : MultLoad;
               state_d = StBusy;
            end
         end
         StBusy: begin
            if (md_load) begin
               // Malformed stream: a new start simply restarts the count.
               count_d = bus.e_md_is_div ? DivLoad : MultLoad;
            end else begin
               count_d = count_q - CntOne;
               if (count_q == CntOne) begin
                  state_d = StIdle;
               end
            end
         end
         default: begin
            state_d = StIdle;
            count_d = '0;
         end
      endcase
   end

   // Busy-counter state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StIdle;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
      end
   end

   // Registered busy flag straight from the counter.
   always_comb begin
      bus.md_busy = (count_q != '0);
   end

`ifdef HAZARD_STALL_PERF_EN
   logic [31:0] stall_cnt_q, md_stall_cnt_q;

   // Performance counters; wrap naturally at 2^32.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt_q    <= '0;
         md_stall_cnt_q <= '0;
      end else begin
         if (bus.Stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (bus.Stall && stall_md) begin
            md_stall_cnt_q <= md_stall_cnt_q + 32'd1;
         end
      end
   end

   // Drive the counter outputs.
   always_comb begin
      bus.stall_cycles    = stall_cnt_q;
      bus.md_stall_cycles = md_stall_cnt_q;
   end
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Scoreboard bench for hazard_stall_ctrl: a driver pushes model expectations each cycle,
// a negedge monitor pops and compares.
module tb_hazard_stall_ctrl;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   hazard_stall_ctrl_if bus();

   hazard_stall_ctrl dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct packed {
      logic        stall;
      logic        busy;
      logic [31:0] sc;
      logic [31:0] mc;
      logic [7:0]  tag;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad = 0;
   int          busy_left = 0;   // cycles the mult/div unit still needs
   int unsigned sc_m = 0;
   int unsigned mc_m = 0;

   function automatic bit hit(int a, int tu);
      return (a != 0) &&
             ((a == int'(bus.e_wa) && tu < int'(bus.e_tnew)) ||
              (a == int'(bus.m_wa) && tu < int'(bus.m_tnew)));
   endfunction

   function automatic bit md_stall();
      return bus.d_isMD && (busy_left != 0 || bus.e_md_start);
   endfunction

   function automatic bit want_stall();
      bit any;
      any = hit(int'(bus.d_rs_addr), int'(bus.d_rs_tuse)) ||
            hit(int'(bus.d_rt_addr), int'(bus.d_rt_tuse)) ||
            md_stall() || (bus.d_isEret && (bus.e_mtc0_epc || bus.m_mtc0_epc));
      return any && !bus.Req;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, got, want);
      end
   endtask

   // Monitor: compare DUT outputs against the queued expectation for this cycle.
   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         check($sformatf("stall[%0d]", e.tag), {31'd0, bus.Stall}, {31'd0, e.stall});
         check($sformatf("flush[%0d]", e.tag), {31'd0, bus.IDEX_Flush}, {31'd0, e.stall});
         check($sformatf("busy[%0d]", e.tag), {31'd0, bus.md_busy}, {31'd0, e.busy});
`ifdef HAZARD_STALL_PERF_EN
         check($sformatf("stall_cycles[%0d]", e.tag), bus.stall_cycles, e.sc);
         check($sformatf("md_stall_cycles[%0d]", e.tag), bus.md_stall_cycles, e.mc);
`endif
      end
   end

   // Push this cycle's expectation, then advance the model across the clock edge.
   task automatic step(input logic [7:0] tag);
      bit s;
      s = want_stall();
      q.push_back('{stall: s, busy: (busy_left != 0), sc: sc_m, mc: mc_m, tag: tag});
      @(posedge clk);
      #1;
      if (s) sc_m++;
      if (s && md_stall()) mc_m++;
      if (bus.e_md_start && !bus.Req) busy_left = bus.e_md_is_div ? 10 : 5;
      else if (busy_left > 0) busy_left--;
   endtask

   task automatic idle();
      bus.Req = 1'b0;
      bus.d_rs_addr = 5'd0;  bus.d_rt_addr = 5'd0;
      bus.d_rs_tuse = 2'd3;  bus.d_rt_tuse = 2'd3;
      bus.e_wa = 5'd0;       bus.e_tnew = 2'd0;
      bus.m_wa = 5'd0;       bus.m_tnew = 2'd0;
      bus.d_isMD = 1'b0;     bus.e_md_start = 1'b0;  bus.e_md_is_div = 1'b0;
      bus.d_isEret = 1'b0;   bus.e_mtc0_epc = 1'b0;  bus.m_mtc0_epc = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      #2;
      // Inputs that would stall: outputs must still be 0 while reset is high.
      bus.d_isMD = 1'b1;
      bus.e_md_start = 1'b1;
      #1;
      check("reset_stall", {31'd0, bus.Stall}, 32'd0);
      check("reset_flush", {31'd0, bus.IDEX_Flush}, 32'd0);
      check("reset_busy", {31'd0, bus.md_busy}, 32'd0);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      idle();
      reset = 1'b0;

      // Load-use on rs, then the same with rs = $0.
      bus.e_wa = 5'd5; bus.e_tnew = 2'd2; bus.d_rs_addr = 5'd5; bus.d_rs_tuse = 2'd1;
      step(8'd1);
      bus.d_rs_addr = 5'd0;
      step(8'd2);

      // M-stage hazard on rt.
      idle();
      bus.m_wa = 5'd8; bus.m_tnew = 2'd1; bus.d_rt_addr = 5'd8; bus.d_rt_tuse = 2'd0;
      step(8'd3);
      bus.d_rt_tuse = 2'd1;
      step(8'd4);

      // Divide with a dependent MD instruction held in D.
      idle();
      bus.d_isMD = 1'b1; bus.e_md_start = 1'b1; bus.e_md_is_div = 1'b1;
      step(8'd5);
      bus.e_md_start = 1'b0;
      repeat (10) step(8'd6);
      step(8'd7);

      // Mult, then Req mid-busy.
      idle();
      bus.d_isMD = 1'b1; bus.e_md_start = 1'b1;
      step(8'd8);
      bus.e_md_start = 1'b0;
      step(8'd9);
      bus.Req = 1'b1;
      step(8'd10);
      bus.Req = 1'b0;
      repeat (3) step(8'd11);
      step(8'd12);

      // Eret behind an mtc0 to EPC.
      idle();
      bus.d_isEret = 1'b1; bus.m_mtc0_epc = 1'b1;
      step(8'd13);
      bus.m_mtc0_epc = 1'b0;
      step(8'd14);

      // Req coincident with a start: the start is dropped.
      idle();
      bus.d_isMD = 1'b1; bus.e_md_start = 1'b1; bus.Req = 1'b1;
      step(8'd15);
      idle();
      bus.d_isMD = 1'b1;
      step(8'd16);

      // Randomized traffic.
      repeat (400) begin
         bus.d_rs_addr   = 5'($urandom_range(0, 3));
         bus.d_rt_addr   = 5'($urandom_range(0, 3));
         bus.d_rs_tuse   = 2'($urandom_range(0, 3));
         bus.d_rt_tuse   = 2'($urandom_range(0, 3));
         bus.e_wa        = 5'($urandom_range(0, 3));
         bus.e_tnew      = 2'($urandom_range(0, 3));
         bus.m_wa        = 5'($urandom_range(0, 3));
         bus.m_tnew      = 2'($urandom_range(0, 3));
         bus.d_isMD      = ($urandom_range(0, 2) == 0);
         bus.e_md_start  = ($urandom_range(0, 7) == 0);
         bus.e_md_is_div = 1'($urandom_range(0, 1));
         bus.d_isEret    = ($urandom_range(0, 3) == 0);
         bus.e_mtc0_epc  = ($urandom_range(0, 3) == 0);
         bus.m_mtc0_epc  = ($urandom_range(0, 3) == 0);
         bus.Req         = ($urandom_range(0, 9) == 0);
         step(8'd20);
      end

      // Let the monitor drain, with a bound.
      idle();
      for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
      if (q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain left=%0d want=0", q.size());
         q.delete();
      end
      step(8'd21);

      // Async reset mid-divide, between clock edges.
      bus.e_md_start = 1'b1; bus.e_md_is_div = 1'b1;
      step(8'd30);
      idle();
      bus.d_isMD = 1'b1;
      repeat (3) step(8'd31);
      check("pre_reset_busy", {31'd0, bus.md_busy}, {31'd0, (busy_left == 7)});
      #2;
      reset = 1'b1;
      busy_left = 0;
      sc_m = 0;
      mc_m = 0;
      #1;
      check("async_busy", {31'd0, bus.md_busy}, 32'd0);
      check("async_stall", {31'd0, bus.Stall}, 32'd0);
`ifdef HAZARD_STALL_PERF_EN
      check("async_stall_cycles", bus.stall_cycles, sc_m);
      check("async_md_stall_cycles", bus.md_stall_cycles, mc_m);
`endif
      @(posedge clk);
      #1;
      reset = 1'b0;
      step(8'd32);
      @(posedge clk);
      #1;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Central stall/flush controller for the 5-stage pipeline.
- Decides each cycle whether PC and the IF/ID register hold (Stall) and whether a bubble enters ID/EX (IDEX_Flush).
- Stall sources: register data hazards (Tuse/Tnew), a multicycle multiply/divide unit, and eret reading EPC while an mtc0 to EPC is still in flight.
- Owns the mult/div busy counter. Exception requests (Req) override all stalling.

Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start.
- DIV_CYCLES, 10, busy cycles after a div/divu start.
- CNT_W, 4, busy-counter width; must hold max(MULT_CYCLES, DIV_CYCLES).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- Req  in  1  exception/interrupt taken this cycle (from CP0)
- d_rs_addr  in  5  rs field of the D-stage instruction
- d_rt_addr  in  5  rt field of the D-stage instruction
- d_rs_tuse  in  2  Tuse of rs; 3 = not used
- d_rt_tuse  in  2  Tuse of rt; 3 = not used
- e_wa  in  5  E-stage destination register
- e_tnew  in  2  E-stage Tnew, measured at E
- m_wa  in  5  M-stage destination register
- m_tnew  in  2  M-stage Tnew, measured at M
- d_isMD  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_md_start  in  1  E-stage instruction starts mult/div this cycle
- e_md_is_div  in  1  qualifies e_md_start: 1 = div, 0 = mult
- d_isEret  in  1  D-stage instruction is eret
- e_mtc0_epc  in  1  E-stage instruction is mtc0 to EPC
- m_mtc0_epc  in  1  M-stage instruction is mtc0 to EPC
- Stall  out  1  hold PC and IF/ID
- IDEX_Flush  out  1  load a bubble into ID/EX
- md_busy  out  1  mult/div unit busy (registered)

Behaviour:
- Reset (asynchronous, active-high): busy counter = 0, md_busy = 0. Stall = 0 and IDEX_Flush = 0 while reset is high.
- Data hazard, evaluated separately for rs and rt, per source X:
  - hazX = (addr != 0) && ((addr == e_wa && tuse < e_tnew) || (addr == m_wa && tuse < m_tnew)).
  - Compare widths are 2-bit unsigned.
  - tuse = 3 never stalls.
- MD hazard: stallMD = d_isMD && (md_busy || e_md_start).
- Eret hazard: stallER = d_isEret && (e_mtc0_epc || m_mtc0_epc).
- stall_any = hazRS | hazRT | stallMD | stallER.
- Outputs are combinational:
  - Stall = stall_any && !Req.
  - IDEX_Flush = stall_any && !Req.
  - When Req is high, both are 0; the pipeline registers flush themselves on Req.
- Busy counter FSM, two states:
  - IDLE (count = 0) -> BUSY on e_md_start && !Req. Load DIV_CYCLES if e_md_is_div, else MULT_CYCLES.
  - BUSY: decrement by 1 each cycle. Return to IDLE when count reaches 0.
  - md_busy = (count != 0). It is registered, so it goes high the cycle after the start.
  - e_md_start while BUSY (only possible with a malformed stream): reload with the new value; no error flag.
  - Req during BUSY: the counter keeps running; an issued operation is not cancelled.
  - Req coincident with e_md_start: the start is ignored and no load occurs.
- Simultaneous hazards: any single source asserts the stall. Priority is irrelevant because the outputs are ORed.
- Latency: stall decision is same-cycle. A D instruction is released in the cycle md_busy returns to 0, provided no other source stalls.

Optional Feature:
- Macro: HAZARD_STALL_PERF_EN.
- When defined:
  - Adds output stall_cycles [31:0]: counts cycles with Stall = 1. Wraps at 2^32 without saturation. Cleared by reset.
  - Adds output md_stall_cycles [31:0]: counts cycles with Stall = 1 and stallMD = 1. Wraps at 2^32 without saturation. Cleared by reset.
- When undefined: neither port nor either counter exists, and all other behaviour is identical.

Test Plan:
- Load-use: e_wa = 5, e_tnew = 2, d_rs_addr = 5, d_rs_tuse = 1 -> Stall = 1, IDEX_Flush = 1. Same with d_rs_addr = 0 -> Stall = 0.
- M-stage hazard: m_wa = 8, m_tnew = 1, d_rt_addr = 8, d_rt_tuse = 0 -> Stall = 1. With d_rt_tuse = 1 -> Stall = 0.
- Divide: e_md_start = 1, e_md_is_div = 1 at cycle t; d_isMD = 1 held -> Stall = 1 from cycle t through t+10; md_busy high for cycles t+1..t+10; Stall = 0 at cycle t+11.
- Mult, then Req mid-busy: e_md_start = 1 (mult); Req = 1 at t+2 -> Stall = 0 in that cycle; md_busy still clears at t+6.
- Eret: d_isEret = 1 with m_mtc0_epc = 1 -> Stall = 1. Next cycle, with m_mtc0_epc = 0 and e_mtc0_epc = 0 -> Stall = 0.
- Async reset: assert reset mid-divide (count = 7) between clock edges -> md_busy = 0 immediately. With HAZARD_STALL_PERF_EN defined, stall_cycles = 0 immediately.
